// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: handshaked binary-to-decimal/hex converter driving active-low seven-segment digits.
module seg_display_ctrl #(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      value,
   input  logic                  hex_mode,
   input  logic                  blank_lz,
   output logic [DIGITS*7-1:0]   segs,
   output logic                  done,
   output logic                  overflow
);
   localparam int BW = 4 * DIGITS;
   localparam int EW = (WIDTH > BW) ? WIDTH : BW;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

   state_t              state_q, state_d;
   logic [BW-1:0]       bcd_q, bcd_d, adj;
   logic [WIDTH-1:0]    bin_q, bin_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                ovf_q, ovf_d;
   logic                blank_q, blank_d;
   logic                phase_q, phase_d;
   logic [DIGITS*7-1:0] stage_q, stage_d, dec;
   logic                stage_ovf_q, stage_ovf_d;
   logic [DIGITS*7-1:0] segs_q, segs_d;
   logic                done_q, done_d;
   logic                overflow_q, overflow_d;
   logic [EW-1:0]       ext;
   logic                accept, seen;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 7'b1000000;
         4'h1: seg7 = 7'b1111001;
         4'h2: seg7 = 7'b0100100;
         4'h3: seg7 = 7'b0110000;
         4'h4: seg7 = 7'b0011001;
         4'h5: seg7 = 7'b0010010;
         4'h6: seg7 = 7'b0000010;
         4'h7: seg7 = 7'b1111000;
         4'h8: seg7 = 7'b0000000;
         4'h9: seg7 = 7'b0010000;
         4'hA: seg7 = 7'b0001000;
         4'hB: seg7 = 7'b0000011;
         4'hC: seg7 = 7'b1000110;
         4'hD: seg7 = 7'b0100001;
         4'hE: seg7 = 7'b0000110;
         default: seg7 = 7'b0001110;
      endcase
   endfunction

   assign in_ready = (state_q == IDLE);
   assign accept   = in_valid && in_ready;
   assign ext      = EW'(value);
   assign segs     = segs_q;
   assign done     = done_q;
   assign overflow = overflow_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         bcd_q       <= '0;
         bin_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         blank_q     <= 1'b0;
         phase_q     <= 1'b0;
         stage_q     <= '1;
         stage_ovf_q <= 1'b0;
         segs_q      <= '1;
         done_q      <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         bcd_q       <= bcd_d;
         bin_q       <= bin_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         blank_q     <= blank_d;
         phase_q     <= phase_d;
         stage_q     <= stage_d;
         stage_ovf_q <= stage_ovf_d;
         segs_q      <= segs_d;
         done_q      <= done_d;
         overflow_q  <= overflow_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = accept ? (hex_mode ? LOAD : CONV) : IDLE;
         CONV:    state_d = (cnt_q == CW'(WIDTH - 1)) ? LOAD : CONV;
         LOAD:    state_d = phase_q ? IDLE : LOAD;
         default: state_d = IDLE;
      endcase
   end

   // Decode is staged one cycle ahead of the outputs so the blanking chain stays off the commit path.
   always_comb begin
      seen = 1'b0;
      dec  = '1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         seen = seen | (bcd_q[4*i +: 4] != 4'h0);
         dec[7*i +: 7] = (blank_q && !ovf_q && !seen && i != 0) ? 7'h7f : seg7(bcd_q[4*i +: 4]);
      end
   end

   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < DIGITS; i++)
         adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
   end

   always_comb begin
      bcd_d       = bcd_q;
      bin_d       = bin_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      blank_d     = blank_q;
      phase_d     = phase_q;
      stage_d     = stage_q;
      stage_ovf_d = stage_ovf_q;
      segs_d      = segs_q;
      overflow_d  = overflow_q;
      done_d      = 1'b0;
      case (state_q)
         IDLE: if (accept) begin
            blank_d = blank_lz;
            cnt_d   = '0;
            phase_d = 1'b0;
            bin_d   = value;
            bcd_d   = hex_mode ? ext[BW-1:0] : '0;
            ovf_d   = hex_mode && (|(ext >> BW));
         end
         CONV: begin
            bcd_d = {adj[BW-2:0], bin_q[WIDTH-1]};
            bin_d = {bin_q[WIDTH-2:0], 1'b0};
            ovf_d = ovf_q | adj[BW-1];
            cnt_d = cnt_q + 1'b1;
         end
         LOAD: begin
            phase_d     = ~phase_q;
            stage_d     = phase_q ? stage_q : dec;
            stage_ovf_d = phase_q ? stage_ovf_q : ovf_q;
            segs_d      = phase_q ? stage_q : segs_q;
            overflow_d  = phase_q ? stage_ovf_q : overflow_q;
            done_d      = phase_q;
         end
         default: ;
      endcase
   end
endmodule
